// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : NUM_CH:1 valid/ready stream multiplexer with a registered
//               output stage. mode=0 selects the channel given by sel,
//               mode=1 arbitrates round-robin among the valid channels.
//               One cycle of latency, one beat per cycle sustained.
//               Optional packet lock: define STREAM_MUX_PKT_LOCK_EN to add
//               in_last/out_last and hold round-robin grants on a channel
//               until the end of its packet.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]   ptr_q,       ptr_d;

  // --------------------------------------------------------------------------
  // Combinational grant signals
  // --------------------------------------------------------------------------
  logic               load;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_ch;
  logic [NUM_CH-1:0]  rr_eligible;
  logic [NUM_CH-1:0]  rr_candidates;

  // Channel index reached after stepping k places from base, wrapping at
  // NUM_CH exactly (NUM_CH need not be a power of two).
  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                input int               k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) begin
      s = s - NUM_CH;
    end
    return SEL_W'(s);
  endfunction

  assign load = !out_valid_q || out_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic               lock_q,     lock_d;
  logic [SEL_W-1:0]   lock_ch_q,  lock_ch_d;
  logic               out_last_q, out_last_d;

  // While a packet is in flight only its channel may win round-robin.
  always_comb begin
    rr_eligible = '1;
    if (lock_q) begin
      rr_eligible = NUM_CH'(1) << lock_ch_q;
    end
  end
`else
  // Every beat is arbitrated independently: all channels are eligible.
  always_comb begin
    rr_eligible = '1;
  end
`endif

  assign rr_candidates = in_valid & rr_eligible;

  // Grant selection; only evaluated when the output register can take a beat.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    if (load) begin
      if (!mode) begin
        // Fixed select: an out-of-range sel simply matches no channel.
        for (int i = 0; i < NUM_CH; i++) begin
          if ((sel == SEL_W'(i)) && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_ch    = SEL_W'(i);
          end
        end
      end else begin
        // Scan from the far end back to ptr so the nearest candidate wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          if (rr_candidates[rr_index(ptr_q, k)]) begin
            grant_valid = 1'b1;
            grant_ch    = rr_index(ptr_q, k);
          end
        end
      end
    end
  end

  // Ready goes back only to the granted channel, and never during reset.
  always_comb begin
    in_ready = '0;
    if (grant_valid && !rst) begin
      in_ready = NUM_CH'(1) << grant_ch;
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_valid;
    end
    if (grant_valid) begin
      out_data_d = in_data[int'(grant_ch)*DATA_W +: DATA_W];
      out_ch_d   = grant_ch;
      if (mode) begin
        ptr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + SEL_W'(1);
      end
    end
  end

  // Output stage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Lock tracking: a non-last round-robin beat locks its channel, a last beat
  // releases it; leaving round-robin mode drops the lock at once.
  always_comb begin
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (!mode) begin
      lock_d = 1'b0;
    end
    if (grant_valid) begin
      out_last_d = in_last[grant_ch];
      if (mode) begin
        lock_d    = !in_last[grant_ch];
        lock_ch_d = grant_ch;
      end
    end
  end

  // Lock state and the end-of-packet flag that travels with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr (4-channel instance
//               plus a 3-channel instance for out-of-range sel and exact
//               wrap). Expected beats are queued by a reference model and
//               popped by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  logic        m3 = 1'b0;
  logic [1:0]  s3 = 2'd0;
  logic [2:0]  v3 = 3'b000;
  logic [2:0]  rdy3;
  logic [23:0] d3 = 24'h0;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  oc3;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  in_last  = 4'hF;
  logic [2:0]  in_last3 = 3'h7;
  logic        out_last;
  logic        out_last3;
`endif

  stream_mux_rr #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(m3), .sel(s3),
    .in_valid(v3), .in_ready(rdy3), .in_data(d3),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_valid(ov3), .out_ready(1'b1),
    .out_data(od3), .out_ch(oc3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  // reference model state
  bit    m_ovalid = 1'b0;
  int    m_ptr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: the front of the queue must be what the DUT presents;
  // it is retired when the consumer accepts it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: out_valid=1 but no beat expected at %0t", $time);
      end else begin
        chk("out_data", {24'h0, out_data}, {24'h0, sb[0].data});
        chk("out_ch", {30'h0, out_ch}, {30'h0, sb[0].ch});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus on the 4-channel DUT followed by the model step.
  task automatic cycle(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy);
    bit   load;
    bit   found;
    int   g;
    int   c;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #1;
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_ovalid});
    load  = !m_ovalid || ordy;
    found = 1'b0;
    g     = 0;
    if (load) begin
      if (!m) begin
        if (int'(s) < NCH && v[s]) begin
          found = 1'b1;
          g     = int'(s);
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (!found && v[c]) begin
            found = 1'b1;
            g     = c;
          end
        end
      end
    end
    exp_rdy = found ? 4'(1 << g) : 4'b0000;
    chk("in_ready", {28'h0, in_ready}, {28'h0, exp_rdy});
    if (found) sb.push_back('{ch: 2'(g), data: d[g*8 +: 8]});
    if (load) m_ovalid = found;
    if (found && m) m_ptr = (g + 1) % NCH;
  endtask

  int exp3[4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = 32'h0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_out_ch", {30'h0, out_ch}, 32'h0);
    chk("rst_in_ready", {28'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // fixed mode, sel=2, everything valid
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'd2, 4'b1111, 32'h13121110, 1'b1);

    // round-robin, all valid
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'd0, 4'b1111, 32'h23222120 + 32'(i), 1'b1);

    // reset asserted mid-stream while a beat is held
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out_data", {24'h0, out_data}, 32'h0);
    chk("mid_rst_out_ch", {30'h0, out_ch}, 32'h0);
    chk("mid_rst_in_ready", {28'h0, in_ready}, 32'h0);
    in_valid = 4'b0000;
    sb.delete();
    m_ovalid = 1'b0;
    m_ptr    = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // first round-robin grant after reset goes to channel 0
    cycle(1'b1, 2'd0, 4'b1111, 32'h33323130, 1'b1);
    chk("post_rst_grant", {28'h0, in_ready}, 32'h1);

    // sparse round-robin, then a single channel
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, 4'b1010, 32'h43424140 + 32'(i << 8), 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 2'd0, 4'b0001, 32'h53525150 + 32'(i), 1'b1);

    // backpressure for three cycles, then release
    cycle(1'b1, 2'd0, 4'b1111, 32'h63626160, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 4'b1111, 32'h73727170 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 4'b1111, 32'h83828180 + 32'(i), 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
            32'($urandom), ($urandom_range(0, 3) != 0));
    end

    // drain the 4-channel DUT before using the 3-channel instance
    cycle(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);

    // 3-channel instance: fixed select, then out-of-range sel
    m3 = 1'b0; s3 = 2'd1; v3 = 3'b111; d3 = 24'h222120;
    #1 chk("c3_in_ready_sel1", {29'h0, rdy3}, 32'h2);
    cycle(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    chk("c3_out_valid_sel1", {31'h0, ov3}, 32'h1);
    chk("c3_out_ch_sel1", {30'h0, oc3}, 32'h1);
    chk("c3_out_data_sel1", {24'h0, od3}, 32'h21);
    s3 = 2'd3;
    #1 chk("c3_in_ready_sel3", {29'h0, rdy3}, 32'h0);
    cycle(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    chk("c3_out_valid_sel3", {31'h0, ov3}, 32'h0);
    chk("c3_out_ch_hold", {30'h0, oc3}, 32'h1);
    chk("c3_out_data_hold", {24'h0, od3}, 32'h21);

    // 3-channel round-robin: pointer untouched by fixed mode, exact wrap
    m3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
      chk("c3_rr_valid", {31'h0, ov3}, 32'h1);
      chk("c3_rr_ch", {30'h0, oc3}, 32'(exp3[i]));
    end
    v3 = 3'b000;

    cycle(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
